// File: rtl/serializer_link_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serializer_link_ctrl: TMDS serializer bring-up (lock, reset, settle, video)  |
// | Optional PRBS7 lane test pattern: define SERIALIZER_LINK_CTRL_PRBS_EN        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serializer_link_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [9:0] BLANK_TOKEN   = 10'b1101010100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clk_lock,
  input  logic       i_en,
  input  logic [9:0] i_tmds_ch0,
  input  logic [9:0] i_tmds_ch1,
  input  logic [9:0] i_tmds_ch2,
  output logic       o_rst_oserdes,
  output logic [9:0] o_tmds_ch0,
  output logic [9:0] o_tmds_ch1,
  output logic [9:0] o_tmds_ch2,
  output logic       o_active,
  output logic [1:0] o_state
`ifdef SERIALIZER_LINK_CTRL_PRBS_EN
  ,
  input  logic       i_prbs,
  output logic       o_prbs_active
`endif
);

  localparam int c_cnt_max = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_rst_tc    = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_settle_tc = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [c_cnt_w-1:0]     cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_go;

  assign w_go    = sync_q[SYNC_STAGES-1] & i_en;
  assign o_state = state_q;

  // Losing go wins over any counter expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!w_go) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
        ST_RESET: begin
          if (cnt_q == c_rst_tc) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == c_settle_tc) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

`ifdef SERIALIZER_LINK_CTRL_PRBS_EN
  logic [6:0] lfsr_q;
  logic [6:0] w_lfsr_nxt;
  logic [9:0] w_prbs_word;
  logic       w_prbs_run;

  // Ten serial steps of x^7+x^6+1 per clock; word bit 0 is generated first.
  function automatic logic [16:0] prbs_step10(input logic [6:0] seed);
    logic [6:0] s;
    logic [9:0] w;
    logic       fb;
    s = seed;
    w = '0;
    for (int k = 0; k < 10; k++) begin
      fb   = s[6] ^ s[5];
      w[k] = fb;
      s    = {s[5:0], fb};
    end
    return {s, w};
  endfunction

  assign {w_lfsr_nxt, w_prbs_word} = prbs_step10(lfsr_q);
  assign w_prbs_run = (state_d == ST_ACTIVE) && i_prbs;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_q        <= 7'h7F;
      o_prbs_active <= 1'b0;
    end else begin
      lfsr_q        <= w_prbs_run ? w_lfsr_nxt : 7'h7F;
      o_prbs_active <= w_prbs_run;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sync_q        <= '0;
      o_rst_oserdes <= 1'b1;
      o_active      <= 1'b0;
      o_tmds_ch0    <= BLANK_TOKEN;
      o_tmds_ch1    <= BLANK_TOKEN;
      o_tmds_ch2    <= BLANK_TOKEN;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], i_clk_lock};
      o_rst_oserdes <= (state_d == ST_IDLE) || (state_d == ST_RESET);
      o_active      <= (state_d == ST_ACTIVE);
      if (state_d != ST_ACTIVE) begin
        o_tmds_ch0 <= BLANK_TOKEN;
        o_tmds_ch1 <= BLANK_TOKEN;
        o_tmds_ch2 <= BLANK_TOKEN;
`ifdef SERIALIZER_LINK_CTRL_PRBS_EN
      end else if (w_prbs_run) begin
        o_tmds_ch0 <= w_prbs_word;
        o_tmds_ch1 <= w_prbs_word;
        o_tmds_ch2 <= w_prbs_word;
`endif
      end else begin
        o_tmds_ch0 <= i_tmds_ch0;
        o_tmds_ch1 <= i_tmds_ch1;
        o_tmds_ch2 <= i_tmds_ch2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializer_link_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serializer_link_ctrl: directed checks of serializer bring-up sequencing  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serializer_link_ctrl;
  localparam logic [9:0] BLANK = 10'b1101010100;

  logic       clk = 1'b0;
  logic       rst, lock, en;
  logic [9:0] ch0, ch1, ch2;
  logic       rst_o, act_o;
  logic [9:0] o0, o1, o2;
  logic [1:0] st_o;
`ifdef SERIALIZER_LINK_CTRL_PRBS_EN
  logic       prbs, prbs_act;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializer_link_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clk_lock   (lock),
    .i_en         (en),
    .i_tmds_ch0   (ch0),
    .i_tmds_ch1   (ch1),
    .i_tmds_ch2   (ch2),
    .o_rst_oserdes(rst_o),
    .o_tmds_ch0   (o0),
    .o_tmds_ch1   (o1),
    .o_tmds_ch2   (o2),
    .o_active     (act_o),
    .o_state      (st_o)
`ifdef SERIALIZER_LINK_CTRL_PRBS_EN
    ,
    .i_prbs       (prbs),
    .o_prbs_active(prbs_act)
`endif
  );

  typedef struct packed {
    int         cyc;
    logic [1:0] st;
    logic       rsto;
    logic       act;
  } bp_t;

  typedef struct packed {
    logic       en;
    logic [9:0] c0, c1, c2;
    logic [1:0] st;
    logic       rsto;
    logic       act;
    logic [9:0] e0, e1, e2;
  } vec_t;

  bp_t  bp[7];
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle n means the n-th rising edge after lock/reset conditions allow go.
  task automatic bringup(input string tag);
    int idx = 0;
    int bad = 0;
    for (int c = 1; c <= 1043; c++) begin
      tick();
      if (c < 1043 && (o0 !== BLANK || o1 !== BLANK || o2 !== BLANK)) bad++;
      if (idx < 7 && bp[idx].cyc == c) begin
        chk($sformatf("%s_state_c%0d", tag, c), 32'(st_o), 32'(bp[idx].st));
        chk($sformatf("%s_rsto_c%0d", tag, c), 32'(rst_o), 32'(bp[idx].rsto));
        chk($sformatf("%s_active_c%0d", tag, c), 32'(act_o), 32'(bp[idx].act));
        idx++;
      end
    end
    chk({tag, "_blank_pre_active"}, 32'(bad), 32'd0);
    chk({tag, "_ch0_active"}, 32'(o0), 32'(ch0));
    chk({tag, "_ch2_active"}, 32'(o2), 32'(ch2));
  endtask

  initial begin
    int n;

    bp[0] = '{1,    2'd0, 1'b1, 1'b0};
    bp[1] = '{2,    2'd0, 1'b1, 1'b0};
    bp[2] = '{3,    2'd1, 1'b1, 1'b0};
    bp[3] = '{18,   2'd1, 1'b1, 1'b0};
    bp[4] = '{19,   2'd2, 1'b0, 1'b0};
    bp[5] = '{1042, 2'd2, 1'b0, 1'b0};
    bp[6] = '{1043, 2'd3, 1'b0, 1'b1};

    vecs[0] = '{1'b1, 10'h2AA, 10'h155, 10'h3FF, 2'd3, 1'b0, 1'b1, 10'h2AA, 10'h155, 10'h3FF};
    vecs[1] = '{1'b1, 10'h000, 10'h001, 10'h200, 2'd3, 1'b0, 1'b1, 10'h000, 10'h001, 10'h200};
    vecs[2] = '{1'b1, 10'h3C3, 10'h0AB, 10'h123, 2'd3, 1'b0, 1'b1, 10'h3C3, 10'h0AB, 10'h123};
    vecs[3] = '{1'b0, 10'h111, 10'h222, 10'h333, 2'd0, 1'b1, 1'b0, BLANK, BLANK, BLANK};
    vecs[4] = '{1'b1, 10'h2AA, 10'h155, 10'h3FF, 2'd1, 1'b1, 1'b0, BLANK, BLANK, BLANK};

    rst = 1'b1; lock = 1'b1; en = 1'b1;
    ch0 = 10'h0F0; ch1 = 10'h30F; ch2 = 10'h111;
`ifdef SERIALIZER_LINK_CTRL_PRBS_EN
    prbs = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_state", 32'(st_o), 32'd0);
    chk("reset_rsto", 32'(rst_o), 32'd1);
    chk("reset_active", 32'(act_o), 32'd0);
    chk("reset_ch1", 32'(o1), 32'(BLANK));
    rst = 1'b0;
    bringup("boot");

    for (int i = 0; i < 5; i++) begin
      en = vecs[i].en; ch0 = vecs[i].c0; ch1 = vecs[i].c1; ch2 = vecs[i].c2;
      tick();
      chk($sformatf("vec%0d_state", i), 32'(st_o), 32'(vecs[i].st));
      chk($sformatf("vec%0d_rsto", i), 32'(rst_o), 32'(vecs[i].rsto));
      chk($sformatf("vec%0d_active", i), 32'(act_o), 32'(vecs[i].act));
      chk($sformatf("vec%0d_ch0", i), 32'(o0), 32'(vecs[i].e0));
      chk($sformatf("vec%0d_ch1", i), 32'(o1), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_ch2", i), 32'(o2), 32'(vecs[i].e2));
    end

    // Now in RESET with counter at 0: SETTLE follows 16 edges later.
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); n++;
      if (st_o == 2'd2) break;
    end
    chk("reset_to_settle_len", 32'(n), 32'd16);

    repeat (50) tick();
    lock = 1'b0;
    tick(); tick();
    chk("lockloss_e2_state", 32'(st_o), 32'd2);
    tick();
    chk("lockloss_e3_state", 32'(st_o), 32'd0);
    chk("lockloss_e3_rsto", 32'(rst_o), 32'd1);
    chk("lockloss_e3_ch0", 32'(o0), 32'(BLANK));
    lock = 1'b1;
    ch0 = 10'h0F0; ch1 = 10'h30F; ch2 = 10'h111;
    bringup("relock");

    // Abort exactly on the RESET terminal-count cycle.
    en = 1'b0; tick();
    en = 1'b1; tick();
    chk("en_reentry_state", 32'(st_o), 32'd1);
    repeat (15) tick();
    chk("en_tc_still_reset", 32'(st_o), 32'd1);
    en = 1'b0; tick();
    chk("en_tc_abort_state", 32'(st_o), 32'd0);
    chk("en_tc_abort_rsto", 32'(rst_o), 32'd1);
    en = 1'b1; tick();
    chk("en_tc_restart_state", 32'(st_o), 32'd1);
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      tick(); n++;
      if (act_o === 1'b1) break;
    end
    chk("restart_to_active_len", 32'(n), 32'd1040);

    ch0 = 10'h2AA; ch1 = 10'h155; ch2 = 10'h3FF;
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rstpulse_state", 32'(st_o), 32'd0);
    chk("rstpulse_rsto", 32'(rst_o), 32'd1);
    chk("rstpulse_active", 32'(act_o), 32'd0);
    chk("rstpulse_ch0", 32'(o0), 32'(BLANK));
    chk("rstpulse_ch1", 32'(o1), 32'(BLANK));
    chk("rstpulse_ch2", 32'(o2), 32'(BLANK));

`ifdef SERIALIZER_LINK_CTRL_PRBS_EN
    ch0 = 10'h0F0; ch1 = 10'h30F; ch2 = 10'h111;
    bringup("prbs_boot");
    chk("prbs_idle_flag", 32'(prbs_act), 32'd0);
    prbs = 1'b1; tick();
    chk("prbs_flag", 32'(prbs_act), 32'd1);
    chk("prbs_w0_ch0", 32'(o0), 32'h040);
    chk("prbs_w0_ch1", 32'(o1), 32'h040);
    chk("prbs_w0_ch2", 32'(o2), 32'h040);
    tick();
    chk("prbs_w1_ch0", 32'(o0), 32'h10C);
    prbs = 1'b0; ch0 = 10'h155; tick();
    chk("prbs_off_flag", 32'(prbs_act), 32'd0);
    chk("prbs_off_ch0", 32'(o0), 32'h155);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serializer_link_ctrl.md
Name: serializer_link_ctrl

Overview:
Sequences bring-up of the three TMDS 10:1 serializer lanes. Waits for the high-speed clock generator to lock, then holds the serializer reset for a fixed interval. It then transmits blanking control tokens until the receiver has settled, and only then passes encoded video through. Sits between the TMDS encoders and the three serializer instances; drives their shared reset and their 10-bit parallel data.

Parameters:
RST_CYCLES, 16, cycles o_rst_oserdes is held high after lock (min 1)
SETTLE_CYCLES, 1024, cycles of blank tokens sent after reset release before ACTIVE (min 1)
SYNC_STAGES, 2, flip-flop stages synchronising i_clk_lock (min 2)
BLANK_TOKEN, 10'b1101010100, control symbol (C1C0=00) driven on all lanes when not ACTIVE

Ports:
i_clk  input  1  parallel (pixel) clock; all logic on rising edge
i_rst  input  1  synchronous reset, active high
i_clk_lock  input  1  MMCM/PLL locked, asynchronous to i_clk
i_en  input  1  link enable; low forces return to IDLE
i_tmds_ch0  input  10  encoded lane 0 symbol from encoder
i_tmds_ch1  input  10  encoded lane 1 symbol
i_tmds_ch2  input  10  encoded lane 2 symbol
o_rst_oserdes  output  1  reset to all serializers, active high
o_tmds_ch0  output  10  lane 0 symbol to serializer
o_tmds_ch1  output  10  lane 1 symbol
o_tmds_ch2  output  10  lane 2 symbol
o_active  output  1  high while video is passed through
o_state  output  2  current state encoding, for debug

Behaviour:
- Clock is i_clk only. Reset i_rst is synchronous, active high.
- Reset values:
  - state=IDLE (o_state=2'd0)
  - o_rst_oserdes=1
  - o_tmds_ch0..2=BLANK_TOKEN
  - o_active=0
  - counter=0
  - synchroniser flops=0
- lock_s: i_clk_lock after SYNC_STAGES flops. go = lock_s & i_en.
- States (o_state): IDLE=0, RESET=1, SETTLE=2, ACTIVE=3.
  - IDLE: o_rst_oserdes=1, counter cleared. go=1 -> RESET next cycle.
  - RESET: o_rst_oserdes=1; counter increments each cycle. After exactly RST_CYCLES cycles in RESET -> SETTLE, counter cleared.
  - SETTLE: o_rst_oserdes=0; lanes=BLANK_TOKEN; counter increments. After exactly SETTLE_CYCLES cycles in SETTLE -> ACTIVE.
  - ACTIVE: o_rst_oserdes=0, o_active=1. o_tmds_chN = i_tmds_chN registered, 1-cycle latency.
- Abort: go=0 in any non-IDLE state -> IDLE on the next edge. This takes priority over counter expiry in the same cycle.
  - IDLE entry: o_rst_oserdes=1 and lanes=BLANK_TOKEN from the same edge; o_active=0.
- Lock-loss latency: from i_clk_lock falling to o_rst_oserdes rising is at most SYNC_STAGES+1 cycles.
- All outputs are registered and derived from the next-state value, so state, o_active, o_rst_oserdes and lane muxing change on the same edge.
- Counter width: $clog2(max(RST_CYCLES,SETTLE_CYCLES)+1). Compare with == terminal count, never wraps.
- i_rst asserted mid-sequence: next edge gives reset values, regardless of state.
- Lanes are never driven with encoder data while o_rst_oserdes=1 or in SETTLE.

Optional Feature:
Macro SERIALIZER_LINK_CTRL_PRBS_EN.
- Defined:
  - Adds input i_prbs (1 bit) and output o_prbs_active (1 bit, reset 0).
  - In ACTIVE with i_prbs=1, all three lanes carry the same 10 bits per cycle from a PRBS7 generator (x^7+x^6+1, seed 7'h7F). The generator advances 10 steps per cycle; bit 0 is the first-generated bit.
  - The LFSR reseeds to 7'h7F whenever not (ACTIVE & i_prbs).
  - o_prbs_active = registered (ACTIVE & i_prbs).
- Not defined: ports absent; ACTIVE always passes encoder data.

Test Plan:
- Lock held at 1, i_en=1, release i_rst at cycle 0 (RST_CYCLES=16, SETTLE_CYCLES=1024, SYNC_STAGES=2) -> state RESET at cycle 3; o_rst_oserdes falls at cycle 19; o_active rises at cycle 1043; state walks 0,1,2,3.
- In ACTIVE, drive i_tmds_ch0=10'h2AA, ch1=10'h155, ch2=10'h3FF for one cycle -> outputs show same values exactly 1 cycle later. BLANK_TOKEN on every lane before ACTIVE.
- Drop i_clk_lock mid-SETTLE -> o_rst_oserdes=1, state=IDLE within 3 cycles; re-assert lock -> full RESET+SETTLE repeated with counters restarted from 0.
- i_en low on the cycle RESET counter reaches RST_CYCLES -> goes to IDLE, not SETTLE.
- i_rst pulsed one cycle while ACTIVE -> next edge: o_active=0, o_rst_oserdes=1, lanes=10'b1101010100, o_state=0.
- With SERIALIZER_LINK_CTRL_PRBS_EN: ACTIVE, i_prbs=1 -> first lane word equals the first 10 PRBS7 bits from seed 7'h7F; all lanes equal. o_prbs_active=1 one cycle after i_prbs. i_prbs=0 -> encoder data resumes next cycle.
